// File: rtl/dmem_ctrl.sv
// Quadword access sequencer for a single-port, byte-wide, synchronous-read data RAM.
// Round-robin arbitration between the M stage and the loader; 8 little-endian byte beats per access.
module dmem_ctrl #(
  parameter int unsigned AW    = 10,
  parameter int unsigned DEPTH = 1024
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          m_req_i,
  input  logic          m_we_i,
  input  logic [63:0]   m_addr_i,
  input  logic [63:0]   m_wdata_i,
  output logic [63:0]   m_rdata_o,
  output logic          m_done_o,
  output logic          m_err_o,
  output logic          m_stall_o,
  input  logic          l_req_i,
  input  logic          l_we_i,
  input  logic [63:0]   l_addr_i,
  input  logic [63:0]   l_wdata_i,
  output logic [63:0]   l_rdata_o,
  output logic          l_done_o,
  output logic          l_err_o,
  output logic          ram_en_o,
  output logic          ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [7:0]    ram_wdata_o,
  input  logic [7:0]    ram_rdata_i
);

  localparam logic [63:0] MaxBase = 64'(DEPTH) - 64'd8;

  typedef enum logic [2:0] {StIdle, StXfer, StRlast, StDone, StErr} state_e;

  state_e        state_q;
  logic [2:0]    cnt_q;
  logic          own_q;   // 1 = loader owns the RAM
  logic          last_q;  // 1 = loader was granted last
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;
  logic [63:0]   asm_q;
  logic [63:0]   m_rdata_q, l_rdata_q;
  logic          m_done_q, m_err_q, l_done_q, l_err_q;

  logic          gnt_l;
  logic          sel_we;
  logic [63:0]   sel_addr, sel_wdata;
  logic [2:0]    prev_cnt;
  logic          xfer;

  // On a tie, the requester not granted last wins.
  assign gnt_l     = l_req_i & (~m_req_i | ~last_q);
  assign sel_we    = gnt_l ? l_we_i    : m_we_i;
  assign sel_addr  = gnt_l ? l_addr_i  : m_addr_i;
  assign sel_wdata = gnt_l ? l_wdata_i : m_wdata_i;
  assign prev_cnt  = cnt_q - 3'd1;
  assign xfer      = (state_q == StXfer);

  assign ram_en_o    = xfer;
  assign ram_we_o    = xfer & we_q;
  assign ram_addr_o  = xfer ? addr_q + AW'(cnt_q) : '0;
  assign ram_wdata_o = (xfer && we_q) ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;

  assign m_rdata_o = m_rdata_q;
  assign l_rdata_o = l_rdata_q;
  assign m_done_o  = m_done_q;
  assign m_err_o   = m_err_q;
  assign l_done_o  = l_done_q;
  assign l_err_o   = l_err_q;
  assign m_stall_o = m_req_i & ~m_done_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      own_q     <= 1'b0;
      last_q    <= 1'b1;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 64'd0;
      asm_q     <= 64'd0;
      m_rdata_q <= 64'd0;
      l_rdata_q <= 64'd0;
      m_done_q  <= 1'b0;
      m_err_q   <= 1'b0;
      l_done_q  <= 1'b0;
      l_err_q   <= 1'b0;
    end else begin
      m_done_q <= 1'b0;
      m_err_q  <= 1'b0;
      l_done_q <= 1'b0;
      l_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (m_req_i || l_req_i) begin
            own_q   <= gnt_l;
            last_q  <= gnt_l;
            we_q    <= sel_we;
            addr_q  <= sel_addr[AW-1:0];
            wdata_q <= sel_wdata;
            cnt_q   <= 3'd0;
            if (sel_addr > MaxBase) begin
              state_q <= StErr;
              if (gnt_l) begin
                l_done_q <= 1'b1;
                l_err_q  <= 1'b1;
              end else begin
                m_done_q <= 1'b1;
                m_err_q  <= 1'b1;
              end
            end else begin
              state_q <= StXfer;
            end
          end
        end
        StXfer: begin
          cnt_q <= cnt_q + 3'd1;
          // Read data lags the address by one beat.
          if (!we_q && cnt_q != 3'd0) asm_q[{prev_cnt, 3'b000} +: 8] <= ram_rdata_i;
          if (cnt_q == 3'd7) begin
            if (we_q) begin
              state_q <= StDone;
              if (own_q) l_done_q <= 1'b1;
              else       m_done_q <= 1'b1;
            end else begin
              state_q <= StRlast;
            end
          end
        end
        StRlast: begin
          asm_q[63:56] <= ram_rdata_i;
          state_q      <= StDone;
          if (own_q) begin
            l_rdata_q <= {ram_rdata_i, asm_q[55:0]};
            l_done_q  <= 1'b1;
          end else begin
            m_rdata_q <= {ram_rdata_i, asm_q[55:0]};
            m_done_q  <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a behavioural byte-wide synchronous-read RAM.
module tb_dmem_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        m_req_i = 1'b0, m_we_i = 1'b0;
  logic [63:0] m_addr_i = 64'd0, m_wdata_i = 64'd0;
  logic [63:0] m_rdata_o;
  logic        m_done_o, m_err_o, m_stall_o;
  logic        l_req_i = 1'b0, l_we_i = 1'b0;
  logic [63:0] l_addr_i = 64'd0, l_wdata_i = 64'd0;
  logic [63:0] l_rdata_o;
  logic        l_done_o, l_err_o;
  logic        ram_en_o, ram_we_o;
  logic [9:0]  ram_addr_o;
  logic [7:0]  ram_wdata_o;
  logic [7:0]  ram_rdata_i = 8'h00;

  logic [7:0]  mem [0:1023];
  bit          mem_init;
  int          en_cnt;
  int          n_tests, n_fail;

  dmem_ctrl #(.AW(10), .DEPTH(1024)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_rdata_o(m_rdata_o), .m_done_o(m_done_o), .m_err_o(m_err_o), .m_stall_o(m_stall_o),
    .l_req_i(l_req_i), .l_we_i(l_we_i), .l_addr_i(l_addr_i), .l_wdata_i(l_wdata_i),
    .l_rdata_o(l_rdata_o), .l_done_o(l_done_o), .l_err_o(l_err_o),
    .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'(i) ^ 8'h5A;
      mem_init <= 1'b1;
    end else if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata_i     <= mem[ram_addr_o];
    end
    if (ram_en_o) en_cnt <= en_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_q(input int base);
    logic [63:0] v;
    for (int k = 0; k < 8; k++) v[8*k +: 8] = mem[base+k];
    return v;
  endfunction

  // Runs one transaction from IDLE; cyc counts clock edges until done is seen.
  task automatic xact(input bit is_l, input bit we, input logic [63:0] addr,
                      input logic [63:0] wd, output int cyc, output logic [63:0] rd,
                      output logic err);
    bit got;
    @(negedge clk_i);
    if (is_l) begin
      l_req_i = 1'b1; l_we_i = we; l_addr_i = addr; l_wdata_i = wd;
    end else begin
      m_req_i = 1'b1; m_we_i = we; m_addr_i = addr; m_wdata_i = wd;
    end
    cyc = 0; rd = 64'd0; err = 1'b0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk_i); #1;
      cyc++;
      if (is_l ? l_done_o : m_done_o) begin
        got = 1'b1;
        rd  = is_l ? l_rdata_o : m_rdata_o;
        err = is_l ? l_err_o : m_err_o;
      end
    end
    if (is_l) l_req_i = 1'b0; else m_req_i = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    @(posedge clk_i); #1;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  initial begin
    int cyc, lc, mc, en0;
    logic [63:0] rd;
    logic err;
    logic [3:0] seq;
    int ndone;
    bit stall_bad;

    repeat (3) @(negedge clk_i);
    check("rst_m_done", 64'(m_done_o), 64'd0);
    check("rst_l_done", 64'(l_done_o), 64'd0);
    check("rst_errs", 64'({m_err_o, l_err_o}), 64'd0);
    check("rst_m_rdata", m_rdata_o, 64'd0);
    check("rst_l_rdata", l_rdata_o, 64'd0);
    check("rst_ram", 64'({ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o}), 64'd0);
    rst_n_i = 1'b1;

    // Basic write then read-back with latency.
    xact(1'b0, 1'b1, 64'h10, 64'h1122334455667788, cyc, rd, err);
    check("wr_latency", 64'(cyc), 64'd9);
    check("wr_err", 64'(err), 64'd0);
    check("wr_ram_bytes", mem_q(16), 64'h1122334455667788);
    xact(1'b0, 1'b0, 64'h10, 64'd0, cyc, rd, err);
    check("rd_latency", 64'(cyc), 64'd10);
    check("rd_data", rd, 64'h1122334455667788);

    // Address boundary.
    xact(1'b0, 1'b1, 64'd1016, 64'hA1B2C3D4E5F60718, cyc, rd, err);
    xact(1'b0, 1'b0, 64'd1016, 64'd0, cyc, rd, err);
    check("top_rd_err", 64'(err), 64'd0);
    check("top_rd_data", rd, 64'hA1B2C3D4E5F60718);
    en0 = en_cnt;
    xact(1'b0, 1'b0, 64'd1017, 64'd0, cyc, rd, err);
    check("oor_err", 64'(err), 64'd1);
    check("oor_latency", 64'(cyc), 64'd1);
    check("oor_rdata_held", rd, 64'hA1B2C3D4E5F60718);
    check("oor_no_ram", 64'(en_cnt - en0), 64'd0);
    xact(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, cyc, rd, err);
    check("wrap_err", 64'(err), 64'd1);
    check("wrap_latency", 64'(cyc), 64'd1);

    // Simultaneous requests at reset exit, held continuously.
    @(negedge clk_i);
    rst_n_i = 1'b0;
    m_req_i = 1'b1; m_we_i = 1'b0; m_addr_i = 64'h10;
    l_req_i = 1'b1; l_we_i = 1'b0; l_addr_i = 64'd1016;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    seq = 4'd0; ndone = 0; cyc = 0;
    while (ndone < 4 && cyc < 100) begin
      @(posedge clk_i); #1;
      cyc++;
      if (m_done_o && l_done_o) check("rr_both_done", 64'd1, 64'd0);
      if (m_done_o || l_done_o) begin
        seq = {seq[2:0], l_done_o};
        ndone++;
      end
    end
    m_req_i = 1'b0; l_req_i = 1'b0;
    check("rr_count", 64'(ndone), 64'd4);
    check("rr_order", 64'(seq), 64'b0101);
    @(posedge clk_i); #1;

    // Loader write occupies the RAM; M arrives at beat 3.
    @(negedge clk_i);
    l_req_i = 1'b1; l_we_i = 1'b1; l_addr_i = 64'h80; l_wdata_i = 64'h0F1E2D3C4B5A6978;
    cyc = 0; lc = 0; mc = 0; stall_bad = 1'b0;
    while (mc == 0 && cyc < 60) begin
      @(posedge clk_i); #1;
      cyc++;
      if (l_done_o) begin lc = cyc; l_req_i = 1'b0; end
      if (m_done_o) begin mc = cyc; m_req_i = 1'b0; end
      else if (m_req_i && !m_stall_o) stall_bad = 1'b1;
      if (cyc == 4) begin
        m_req_i = 1'b1; m_we_i = 1'b1; m_addr_i = 64'h90; m_wdata_i = 64'h8877665544332211;
      end
    end
    m_req_i = 1'b0;
    check("occ_l_latency", 64'(lc), 64'd9);
    check("occ_m_done_at", 64'(mc), 64'd19);
    check("occ_m_stall", 64'(stall_bad), 64'd0);
    check("occ_l_bytes", mem_q(128), 64'h0F1E2D3C4B5A6978);
    check("occ_m_bytes", mem_q(144), 64'h8877665544332211);
    @(posedge clk_i); #1;

    // Loader read leaves M read data alone.
    xact(1'b0, 1'b0, 64'h10, 64'd0, cyc, rd, err);
    xact(1'b1, 1'b0, 64'h80, 64'd0, cyc, rd, err);
    check("l_rd_data", rd, 64'h0F1E2D3C4B5A6978);
    check("m_rdata_held", m_rdata_o, 64'h1122334455667788);

    // Reset at beat 4 of an M write.
    @(negedge clk_i);
    m_req_i = 1'b1; m_we_i = 1'b1; m_addr_i = 64'h40; m_wdata_i = 64'hCAFEBABEDEADBEEF;
    cyc = 0;
    while (!(ram_en_o && ram_addr_o == 10'h44) && cyc < 20) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("rst_beat_reached", 64'(cyc), 64'd5);
    rst_n_i = 1'b0;
    m_req_i = 1'b0;
    #1;
    check("mid_rst_ram", 64'({ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o}), 64'd0);
    check("mid_rst_out", 64'({m_done_o, m_err_o, l_done_o, l_err_o}), 64'd0);
    check("mid_rst_rdata", m_rdata_o | l_rdata_o, 64'd0);
    repeat (2) @(negedge clk_i);
    check("partial_bytes", mem_q(64), {8'h47 ^ 8'h5A, 8'h46 ^ 8'h5A, 8'h45 ^ 8'h5A,
                                       8'h44 ^ 8'h5A, 32'hDEADBEEF});
    rst_n_i = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
